// File: rtl/decimal_keypad_scanner.sv
// Synchronises and debounces ten digit key lines into a held one-hot digit plus press strobes.
// Optional build macro KEY_REPEAT_EN adds held-key auto-repeat every REPEAT_CYCLES cycles.
module decimal_keypad_scanner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keys,
  output logic [9:0] digit,
  output logic       valid,
  output logic       err,
  output logic       key_down
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("decimal_keypad_scanner: DEBOUNCE_CYCLES must be >= 1 and REPEAT_CYCLES >= 2");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    cand_q, cand_d;
  logic [9:0]    digit_d;
  logic          valid_d, err_d;
  logic [9:0]    ks_meta, ks;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_meta <= '0;
      ks      <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      digit   <= 10'b00_0000_0001;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      ks_meta <= keys;
      ks      <= ks_meta;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      digit   <= digit_d;
      valid   <= valid_d;
      err     <= err_d;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep_ok_q, rep_ok_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q   <= '0;
      rep_ok_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      rep_ok_q <= rep_ok_d;
    end
  end
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    digit_d = digit;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    rcnt_d   = rcnt_q;
    rep_ok_d = rep_ok_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ks != '0) begin
          cand_d  = ks;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (ks == '0) begin
          state_d = IDLE;
        end else if (ks != cand_q) begin
          cand_d = ks;
          cnt_d  = '0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = HELD;
          // Multi-key patterns are flagged but never reach the one-hot digit output.
          if ($onehot(cand_q)) begin
            digit_d = cand_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
`ifdef KEY_REPEAT_EN
          rcnt_d   = '0;
          rep_ok_d = $onehot(cand_q);
`endif
        end
      end
      HELD: begin
        if (ks == '0) begin
          cnt_d   = '0;
          state_d = RELEASE;
`ifdef KEY_REPEAT_EN
          rcnt_d = '0;
        end else if (rep_ok_q) begin
          if (rcnt_q == REP_LAST) begin
            valid_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
`endif
        end
      end
      RELEASE: begin
        if (ks != '0) begin
          state_d = HELD;
`ifdef KEY_REPEAT_EN
          rcnt_d = '0;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_down = (state_q == HELD) || (state_q == RELEASE);

endmodule

// File: tb/tb_decimal_keypad_scanner.sv
// Scoreboard bench for decimal_keypad_scanner: expected strobes are queued with their cycle and
// checked as the DUT emits them. Define KEY_REPEAT_EN to also exercise auto-repeat.
module tb_decimal_keypad_scanner;

  localparam int D   = 4;
  localparam int R   = 16;
  localparam int LAT = D + 3;  // drive cycle to the cycle count at which the strobe is visible

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] keys;
  logic [9:0] digit;
  logic       valid, err, key_down;

  typedef struct {
    logic       is_err;
    logic [9:0] dig;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  decimal_keypad_scanner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .keys(keys), .digit(digit),
    .valid(valid), .err(err), .key_down(key_down)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic is_err, input logic [9:0] dig, input int at);
    ev_t e;
    e.is_err = is_err;
    e.dig    = dig;
    e.cyc    = at;
    sb.push_back(e);
  endtask

  // Monitor: every strobe must match the head of the scoreboard exactly.
  always @(negedge clk) begin
    if (!rst && (valid || err)) begin
      check("valid_err_exclusive", {31'b0, valid & err}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'b0, valid, err}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("strobe_kind", {31'b0, err}, {31'b0, e.is_err});
        check("strobe_digit", {22'b0, digit}, {22'b0, e.dig});
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [9:0] last_dig;
    rst  = 1'b1;
    keys = '0;
    step(3);
    rst = 1'b0;
    step(2);
    check("rst_digit", {22'b0, digit}, 32'h001);
    check("rst_key_down", {31'b0, key_down}, 32'd0);

    // Clean press then release timing
    t = cyc; keys = 10'b00_0000_1000; push(1'b0, 10'b00_0000_1000, t + LAT);
    step(15);
    check("clean_digit", {22'b0, digit}, 32'h008);
    check("clean_key_down", {31'b0, key_down}, 32'd1);
    keys = '0; t = cyc;
    while (cyc < t + LAT - 1) step(1);
    check("release_kd_still_high", {31'b0, key_down}, 32'd1);
    step(1);
    check("release_kd_low", {31'b0, key_down}, 32'd0);
    step(4);

    // Bounce: accept timing from the final transition
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? 10'b00_0001_0000 : 10'b0;
      t = cyc;
      step(2);
    end
    push(1'b0, 10'b00_0001_0000, t + LAT);
    step(13);
    check("bounce_digit", {22'b0, digit}, 32'h010);
    keys = '0;
    step(12);

    // Multi-key: err strobe, digit kept
    last_dig = 10'b00_0001_0000;
    t = cyc; keys = 10'b00_0000_0110; push(1'b1, last_dig, t + LAT);
    step(15);
    check("multi_digit_kept", {22'b0, digit}, {22'b0, last_dig});
    check("multi_key_down", {31'b0, key_down}, 32'd1);
    keys = '0;
    step(12);

    // Short glitch: no strobe, stays idle
    keys = 10'b10_0000_0000;
    step(2);
    keys = '0;
    for (int i = 0; i < 10; i++) begin
      check("glitch_key_down", {31'b0, key_down}, 32'd0);
      step(1);
    end
    check("glitch_digit", {22'b0, digit}, {22'b0, last_dig});

    // Reset mid-debounce, key still held afterwards is a fresh press
    keys = 10'b00_1000_0000;
    step(4);
    rst = 1'b1;
    #1;
    check("midrst_digit", {22'b0, digit}, 32'h001);
    check("midrst_valid", {31'b0, valid}, 32'd0);
    check("midrst_err", {31'b0, err}, 32'd0);
    check("midrst_key_down", {31'b0, key_down}, 32'd0);
    step(2);
    rst = 1'b0;
    t = cyc; push(1'b0, 10'b00_1000_0000, t + LAT);
    step(15);
    check("postrst_digit", {22'b0, digit}, 32'h080);
    keys = '0;
    step(12);

`ifdef KEY_REPEAT_EN
    // Auto-repeat while held, none after release
    t = cyc; keys = 10'b01_0000_0000;
    for (int k = 0; k < 4; k++) push(1'b0, 10'b01_0000_0000, t + LAT + k * R);
    step(60);
    keys = '0;
    step(30);
`endif

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
